// File: rtl/serial_pattern_gen.sv
// Serial pattern generator: shifts a captured 8-bit pattern out MSB first,
// LEN bits per frame, REPS+1 frames per burst, then pulses DONE for one cycle.
module serial_pattern_gen (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       START,
   input  logic [7:0] PATTERN,
   input  logic [3:0] LEN,
   input  logic [2:0] REPS,
   output logic       X,
   output logic       X_VALID,
   output logic       FRAME_END,
   output logic       BUSY,
   output logic       DONE
);

   localparam int unsigned PAT_W = 8;
   localparam int unsigned CNT_W = 3;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEND = 2'd1,
      S_FIN  = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [PAT_W-1:0]   pat_q, pat_d;
   logic [CNT_W-1:0]   last_bit_q, last_bit_d;
   logic [CNT_W-1:0]   reps_q, reps_d;
   logic [CNT_W-1:0]   bit_q, bit_d;
   logic [CNT_W-1:0]   frm_q, frm_d;
   logic               x_q, x_d;
   logic               x_valid_q, x_valid_d;
   logic               frame_end_q, frame_end_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   // Next state; outputs are computed for the bit that becomes visible after the edge
   always_comb begin
      state_d     = state_q;
      pat_d       = pat_q;
      last_bit_d  = last_bit_q;
      reps_d      = reps_q;
      bit_d       = bit_q;
      frm_d       = frm_q;
      x_d         = 1'b0;
      x_valid_d   = 1'b0;
      frame_end_d = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (START) begin
               pat_d       = PATTERN;
               last_bit_d  = ((LEN == 4'd0) || (LEN > 4'd8)) ? 3'd7 : CNT_W'(LEN - 4'd1);
               reps_d      = REPS;
               bit_d       = '0;
               frm_d       = '0;
               state_d     = S_SEND;
               x_d         = PATTERN[PAT_W-1];
               x_valid_d   = 1'b1;
               busy_d      = 1'b1;
               frame_end_d = (last_bit_d == 3'd0);
            end
         end
         S_SEND: begin
            if ((bit_q == last_bit_q) && (frm_q == reps_q)) begin
               state_d = S_FIN;
               bit_d   = '0;
               frm_d   = '0;
               done_d  = 1'b1;
            end else begin
               if (bit_q == last_bit_q) begin
                  bit_d = '0;
                  frm_d = frm_q + 3'd1;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
               x_d         = pat_q[3'd7 - bit_d];
               x_valid_d   = 1'b1;
               busy_d      = 1'b1;
               frame_end_d = (bit_d == last_bit_q);
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and registered outputs with synchronous reset
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q     <= S_IDLE;
         pat_q       <= '0;
         last_bit_q  <= '0;
         reps_q      <= '0;
         bit_q       <= '0;
         frm_q       <= '0;
         x_q         <= 1'b0;
         x_valid_q   <= 1'b0;
         frame_end_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pat_q       <= pat_d;
         last_bit_q  <= last_bit_d;
         reps_q      <= reps_d;
         bit_q       <= bit_d;
         frm_q       <= frm_d;
         x_q         <= x_d;
         x_valid_q   <= x_valid_d;
         frame_end_q <= frame_end_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign X         = x_q;
   assign X_VALID   = x_valid_q;
   assign FRAME_END = frame_end_q;
   assign BUSY      = busy_q;
   assign DONE      = done_q;

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Bench for serial_pattern_gen: per-cycle expected output vectors
// {X, X_VALID, FRAME_END, BUSY, DONE} are queued at stimulus time and popped each cycle.
module tb_serial_pattern_gen;

   logic       CLK;
   logic       RESET;
   logic       START;
   logic [7:0] PATTERN;
   logic [3:0] LEN;
   logic [2:0] REPS;
   logic       X;
   logic       X_VALID;
   logic       FRAME_END;
   logic       BUSY;
   logic       DONE;

   int         total;
   int         bad;
   logic [4:0] exp_q[$];

   serial_pattern_gen dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .START     (START),
      .PATTERN   (PATTERN),
      .LEN       (LEN),
      .REPS      (REPS),
      .X         (X),
      .X_VALID   (X_VALID),
      .FRAME_END (FRAME_END),
      .BUSY      (BUSY),
      .DONE      (DONE)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Reference model of one burst: bit entries then a DONE entry
   function automatic void push_burst(input logic [7:0] p, input logic [3:0] l, input logic [2:0] r);
      int         len;
      logic [4:0] e;
      len = ((l == 4'd0) || (l > 4'd8)) ? 8 : int'(l);
      for (int f = 0; f <= int'(r); f++) begin
         for (int i = 0; i < len; i++) begin
            e = {p[7-i], 1'b1, (i == len - 1), 1'b1, 1'b0};
            exp_q.push_back(e);
         end
      end
      exp_q.push_back(5'b00001);
   endfunction

   task automatic test_reset();
      logic [4:0] got;
      RESET = 1'b1;
      START = 1'b1;
      PATTERN = 8'hFF;
      LEN = 4'd3;
      REPS = 3'd1;
      @(posedge CLK); #1;
      for (int c = 0; c < 3; c++) begin
         @(negedge CLK);
         got = {X, X_VALID, FRAME_END, BUSY, DONE};
         total++;
         if (got !== 5'b00000) begin
            bad++;
            $display("FAIL reset cyc=%0d got=%b exp=%b", c, got, 5'b00000);
         end
         @(posedge CLK); #1;
      end
      START = 1'b0;
      RESET = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge CLK);
         got = {X, X_VALID, FRAME_END, BUSY, DONE};
         total++;
         if (got !== 5'b00000) begin
            bad++;
            $display("FAIL idle_after_reset cyc=%0d got=%b exp=%b", c, got, 5'b00000);
         end
         @(posedge CLK); #1;
      end
   endtask

   task automatic test_basic();
      logic [4:0] got;
      logic [4:0] exp;
      PATTERN = 8'b1001_0000;
      LEN = 4'd4;
      REPS = 3'd4;
      START = 1'b1;
      exp_q.push_back(5'b00000);
      push_burst(PATTERN, LEN, REPS);
      for (int c = 0; c < 25; c++) begin
         @(negedge CLK);
         exp = (exp_q.size() > 0) ? exp_q.pop_front() : 5'b00000;
         got = {X, X_VALID, FRAME_END, BUSY, DONE};
         total++;
         if (got !== exp) begin
            bad++;
            $display("FAIL basic cyc=%0d got=%b exp=%b", c, got, exp);
         end
         @(posedge CLK); #1;
         START = 1'b0;
      end
   endtask

   task automatic test_single();
      logic [4:0] got;
      logic [4:0] exp;
      PATTERN = 8'h80;
      LEN = 4'd1;
      REPS = 3'd0;
      START = 1'b1;
      exp_q.push_back(5'b00000);
      exp_q.push_back(5'b11110);
      exp_q.push_back(5'b00001);
      for (int c = 0; c < 5; c++) begin
         @(negedge CLK);
         exp = (exp_q.size() > 0) ? exp_q.pop_front() : 5'b00000;
         got = {X, X_VALID, FRAME_END, BUSY, DONE};
         total++;
         if (got !== exp) begin
            bad++;
            $display("FAIL single cyc=%0d got=%b exp=%b", c, got, exp);
         end
         @(posedge CLK); #1;
         START = 1'b0;
      end
   endtask

   task automatic test_len_clamp();
      logic [4:0] got;
      logic [4:0] exp;
      logic [3:0] lens[3];
      lens[0] = 4'd0;
      lens[1] = 4'd12;
      lens[2] = 4'd8;
      for (int k = 0; k < 3; k++) begin
         PATTERN = 8'hA5;
         LEN = lens[k];
         REPS = 3'd0;
         START = 1'b1;
         exp_q.push_back(5'b00000);
         for (int i = 0; i < 8; i++) begin
            exp = {PATTERN[7-i], 1'b1, (i == 7), 1'b1, 1'b0};
            exp_q.push_back(exp);
         end
         exp_q.push_back(5'b00001);
         for (int c = 0; c < 12; c++) begin
            @(negedge CLK);
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 5'b00000;
            got = {X, X_VALID, FRAME_END, BUSY, DONE};
            total++;
            if (got !== exp) begin
               bad++;
               $display("FAIL len_clamp len=%0d cyc=%0d got=%b exp=%b", lens[k], c, got, exp);
            end
            @(posedge CLK); #1;
            START = 1'b0;
         end
      end
   endtask

   task automatic test_disturb();
      logic [4:0] got;
      logic [4:0] exp;
      int         n_valid;
      int         n_done;
      PATTERN = 8'b1011_0000;
      LEN = 4'd4;
      REPS = 3'd2;
      START = 1'b1;
      n_valid = 0;
      n_done = 0;
      exp_q.push_back(5'b00000);
      push_burst(PATTERN, LEN, REPS);
      for (int c = 0; c < 18; c++) begin
         @(negedge CLK);
         exp = (exp_q.size() > 0) ? exp_q.pop_front() : 5'b00000;
         got = {X, X_VALID, FRAME_END, BUSY, DONE};
         n_valid += int'(X_VALID);
         n_done += int'(DONE);
         total++;
         if (got !== exp) begin
            bad++;
            $display("FAIL disturb cyc=%0d got=%b exp=%b", c, got, exp);
         end
         @(posedge CLK); #1;
         if (c < 10) begin
            PATTERN = 8'($urandom);
            LEN = 4'($urandom);
            REPS = 3'($urandom);
            START = c[0];
         end else begin
            START = (c == 12);
         end
      end
      total++;
      if ((n_valid != 12) || (n_done != 1)) begin
         bad++;
         $display("FAIL disturb_counts got valid=%0d done=%0d exp valid=12 done=1", n_valid, n_done);
      end
   endtask

   task automatic test_reset_mid();
      logic [4:0] got;
      logic [4:0] exp;
      PATTERN = 8'b1101_0000;
      LEN = 4'd4;
      REPS = 3'd2;
      START = 1'b1;
      exp_q.push_back(5'b00000);
      push_burst(PATTERN, LEN, REPS);
      // keep only entries up to bit 2 of frame 1; reset lands on the following edge
      while (exp_q.size() > 8) void'(exp_q.pop_back());
      for (int c = 0; c < 14; c++) begin
         @(negedge CLK);
         exp = (exp_q.size() > 0) ? exp_q.pop_front() : 5'b00000;
         got = {X, X_VALID, FRAME_END, BUSY, DONE};
         total++;
         if (got !== exp) begin
            bad++;
            $display("FAIL reset_mid cyc=%0d got=%b exp=%b", c, got, exp);
         end
         @(posedge CLK); #1;
         START = (c == 6);
         RESET = (c == 6);
      end
      PATTERN = 8'b0110_0000;
      LEN = 4'd3;
      REPS = 3'd1;
      START = 1'b1;
      exp_q.push_back(5'b00000);
      push_burst(PATTERN, LEN, REPS);
      for (int c = 0; c < 10; c++) begin
         @(negedge CLK);
         exp = (exp_q.size() > 0) ? exp_q.pop_front() : 5'b00000;
         got = {X, X_VALID, FRAME_END, BUSY, DONE};
         total++;
         if (got !== exp) begin
            bad++;
            $display("FAIL after_reset_burst cyc=%0d got=%b exp=%b", c, got, exp);
         end
         @(posedge CLK); #1;
         START = 1'b0;
      end
   endtask

   task automatic test_back_to_back();
      logic [4:0] got;
      logic [4:0] exp;
      PATTERN = 8'b0100_0000;
      LEN = 4'd2;
      REPS = 3'd0;
      START = 1'b1;
      exp_q.push_back(5'b00000);
      for (int b = 0; b < 8; b++) begin
         push_burst(PATTERN, LEN, REPS);
         exp_q.push_back(5'b00000);
      end
      for (int c = 0; c < 38; c++) begin
         @(negedge CLK);
         exp = (exp_q.size() > 0) ? exp_q.pop_front() : 5'b00000;
         got = {X, X_VALID, FRAME_END, BUSY, DONE};
         total++;
         if (got !== exp) begin
            bad++;
            $display("FAIL back_to_back cyc=%0d got=%b exp=%b", c, got, exp);
         end
         @(posedge CLK); #1;
         if (c == 29) START = 1'b0;
      end
   endtask

   initial begin
      total = 0;
      bad = 0;
      RESET = 1'b1;
      START = 1'b0;
      PATTERN = '0;
      LEN = '0;
      REPS = '0;
      test_reset();
      test_basic();
      test_single();
      test_len_clamp();
      test_disturb();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/serial_pattern_gen.md
SERIAL_PATTERN_GEN -- requirements
Module: serial_pattern_gen

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 CLK  input  1  sole clock; all state changes on rising edge.
REQ-003 RESET  input  1  synchronous, active-high reset.
REQ-004 START  input  1  request to begin a burst; sampled only in IDLE.
REQ-005 PATTERN  input  8  frame bits, transmitted MSB (bit 7) first.
REQ-006 LEN  input  4  bits per frame; 1..8 valid; 0 or >8 treated as 8.
REQ-007 REPS  input  3  frames per burst minus one (burst = REPS+1 frames, 1..8).
REQ-008 X  output  1  serial data bit; 0 whenever X_VALID=0.
REQ-009 X_VALID  output  1  high on every cycle X carries a pattern bit.
REQ-010 FRAME_END  output  1  high during the last bit of each frame.
REQ-011 BUSY  output  1  high while in SEND.
REQ-012 DONE  output  1  one-cycle pulse after the last bit of a burst.

Function
REQ-013 SHALL be a Moore machine: every output registered, a function of state and internal registers only, with no combinational path from any input to any output.
REQ-014 States SHALL be IDLE, SEND, FIN.
REQ-015 IDLE: if START=1 at a rising edge, capture PATTERN, LEN (clamped per REQ-006), REPS; go to SEND; else stay.
REQ-016 SEND: each cycle present one bit; X_VALID=1, BUSY=1.
REQ-017 First bit SHALL appear the cycle after START is sampled (latency 1), value = captured PATTERN[7].
REQ-018 Within a frame, bit i (i=0..L-1) SHALL equal captured PATTERN[7-i].
REQ-019 After bit L-1 with frames remaining: next cycle SHALL be bit 0 of the next frame (no gap cycle); pattern reloaded from the captured copy.
REQ-020 After bit L-1 of the last frame: go to FIN.
REQ-021 FIN: DONE=1, BUSY=0, X_VALID=0, X=0 for exactly one cycle, then IDLE unconditionally; START ignored in FIN.
REQ-022 Burst timing: START sampled at edge k -> valid bits on cycles k+1 .. k+(REPS+1)*L; DONE on cycle k+(REPS+1)*L+1; earliest new START accepted at edge k+(REPS+1)*L+2.
REQ-023 Changes to PATTERN, LEN, REPS, START during SEND or FIN SHALL have no effect on the burst in progress.
REQ-024 START held high continuously SHALL start a new burst each time IDLE is re-entered.
REQ-025 Frame bit counter SHALL be 3 bits (0..7) and frame counter 3 bits (0..7); no wrap-around beyond the captured limits.
REQ-026 In IDLE, all outputs SHALL be 0.

Reset
REQ-027 RESET=1 at a rising edge SHALL force IDLE and clear all outputs and internal registers to 0 on the following cycle, overriding START.
REQ-028 RESET asserted mid-burst SHALL abort it with no DONE pulse; the abandoned burst SHALL NOT resume after RESET deasserts.
REQ-029 START sampled in the same edge as RESET=1 SHALL be ignored.

Verification
REQ-030 PATTERN=8'b1001_0000, LEN=4, REPS=4, 1-cycle START -> X = 1,0,0,1 repeated 5 times on 20 consecutive X_VALID cycles, FRAME_END on cycles 4,8,12,16,20, DONE on cycle 21, BUSY high cycles 1..20.
REQ-031 PATTERN=8'h80, LEN=1, REPS=0 -> single valid bit X=1 with FRAME_END=1, DONE next cycle.
REQ-032 PATTERN=8'hA5, LEN=0 -> 8 bits 1,0,1,0,0,1,0,1 (LEN treated as 8); LEN=12 gives identical result.
REQ-033 Burst LEN=4, REPS=2; toggle PATTERN/LEN/REPS and pulse START during SEND -> output identical to undisturbed burst, exactly 12 bits, one DONE.
REQ-034 RESET=1 during bit 2 of frame 1 -> next cycle all outputs 0, state IDLE, no DONE; new START after release produces a full correct burst.
REQ-035 START held high for 30 cycles, LEN=2, REPS=0 -> bursts repeat with period 4 cycles (2 bits, DONE, IDLE), X=0 and X_VALID=0 on every DONE and IDLE cycle.
